// File: rtl/lstm_pkg.sv
// Shared LSTM scheduler types, default dimensions and sizing helper.
package lstm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_STEP_END,
    S_DONE
  } state_e;

  localparam int unsigned LSTM_N_COLS  = 53;
  localparam int unsigned LSTM_N_ROWS  = 16;
  localparam int unsigned LSTM_N_STEPS = 8;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lstm_step_sched_addr_cnt.sv
// Enable/clear/increment counter with terminal-count flag at MAX.
module addr_cnt #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q;

  // Clear has priority over increment and ignores the enable.
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i && inc_i) cnt_q <= cnt_q + WIDTH'(1);
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == MAX_V);

endmodule

// File: rtl/lstm_step_sched.sv
// Weight-address scheduler for one LSTM sequence: rows of N_COLS reads,
// a drain pause after each row, N_ROWS rows per step, N_STEPS steps.
module lstm_step_sched
  import lstm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned N_COLS     = LSTM_N_COLS,
  parameter int unsigned N_ROWS     = LSTM_N_ROWS,
  parameter int unsigned PAUSE_LEN  = 4,
  parameter int unsigned N_STEPS    = LSTM_N_STEPS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_en,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_addr_vld,
  output logic                  o_mac_clr,
  output logic                  o_act_go,
  output logic [ADDR_WIDTH-1:0] o_row,
  output logic                  o_step_done,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned PW    = cw(PAUSE_LEN);
  localparam int unsigned SW    = cw(N_STEPS);
  localparam int unsigned P_MAX = (PAUSE_LEN == 0) ? 0 : PAUSE_LEN - 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] col_cnt, row_cnt;
  logic [PW-1:0]         pause_cnt_unused;
  logic [SW-1:0]         step_cnt_unused;
  logic col_tc, row_tc, p_tc, s_tc;
  logic col_clr, col_inc, row_clr, row_inc, p_clr, p_inc, s_clr, s_inc;

  logic vld_d, clr_d, act_d, sd_d, busy_d, done_d;
  logic [ADDR_WIDTH-1:0] addr_o_q, row_o_q;
  logic vld_q, clr_q, act_q, sd_q, busy_q, done_q;

  addr_cnt #(.WIDTH(ADDR_WIDTH), .MAX(N_COLS - 1)) u_col (
    .clk(clk), .rst(rst), .en_i(i_en), .clr_i(col_clr), .inc_i(col_inc),
    .cnt_o(col_cnt), .tc_o(col_tc));

  addr_cnt #(.WIDTH(ADDR_WIDTH), .MAX(N_ROWS - 1)) u_row (
    .clk(clk), .rst(rst), .en_i(i_en), .clr_i(row_clr), .inc_i(row_inc),
    .cnt_o(row_cnt), .tc_o(row_tc));

  addr_cnt #(.WIDTH(PW), .MAX(P_MAX)) u_pause (
    .clk(clk), .rst(rst), .en_i(i_en), .clr_i(p_clr), .inc_i(p_inc),
    .cnt_o(pause_cnt_unused), .tc_o(p_tc));

  addr_cnt #(.WIDTH(SW), .MAX(N_STEPS - 1)) u_step (
    .clk(clk), .rst(rst), .en_i(i_en), .clr_i(s_clr), .inc_i(s_inc),
    .cnt_o(step_cnt_unused), .tc_o(s_tc));

  // State and running address register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state, counter control and running address; abort overrides all.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_clr = 1'b0; col_inc = 1'b0;
    row_clr = 1'b0; row_inc = 1'b0;
    p_clr   = 1'b0; p_inc   = 1'b0;
    s_clr   = 1'b0; s_inc   = 1'b0;
    if (i_en) begin
      case (state_q)
        S_IDLE: if (i_start) begin
          state_d = S_RUN;
          addr_d  = '0;
          col_clr = 1'b1; row_clr = 1'b1; p_clr = 1'b1; s_clr = 1'b1;
        end
        S_RUN: begin
          col_inc = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          if (col_tc) begin
            col_clr = 1'b1;
            // Without a drain pause the row boundary is taken straight from RUN.
            if (PAUSE_LEN != 0) begin
              state_d = S_PAUSE;
              p_clr   = 1'b1;
            end else if (row_tc) begin
              state_d = S_STEP_END;
            end else begin
              row_inc = 1'b1;
            end
          end
        end
        S_PAUSE: begin
          p_inc = 1'b1;
          if (p_tc) begin
            p_clr = 1'b1;
            if (row_tc) state_d = S_STEP_END;
            else begin
              row_inc = 1'b1;
              state_d = S_RUN;
            end
          end
        end
        S_STEP_END: begin
          addr_d  = '0;
          row_clr = 1'b1; col_clr = 1'b1; p_clr = 1'b1;
          if (s_tc) begin
            state_d = S_DONE;
            s_clr   = 1'b1;
          end else begin
            state_d = S_RUN;
            s_inc   = 1'b1;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    if (i_abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
      col_clr = 1'b1; row_clr = 1'b1; p_clr = 1'b1; s_clr = 1'b1;
      col_inc = 1'b0; row_inc = 1'b0; p_inc = 1'b0; s_inc = 1'b0;
    end
  end

  // Output decode from the current state; pulses need i_en.
  always_comb begin
    vld_d  = i_en && (state_q == S_RUN);
    clr_d  = vld_d && (col_cnt == '0);
    act_d  = i_en && (((state_q == S_RUN) && col_tc && (PAUSE_LEN == 0)) ||
                      ((state_q == S_PAUSE) && p_tc));
    sd_d   = i_en && (state_q == S_STEP_END);
    done_d = i_en && (state_q == S_DONE);
    busy_d = (state_q != S_IDLE);
  end

  // Registered outputs, forced to zero by reset or abort.
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      addr_o_q <= '0; row_o_q <= '0;
      vld_q <= 1'b0; clr_q <= 1'b0; act_q <= 1'b0;
      sd_q  <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      addr_o_q <= addr_q; row_o_q <= row_cnt;
      vld_q <= vld_d; clr_q <= clr_d; act_q <= act_d;
      sd_q  <= sd_d;  busy_q <= busy_d; done_q <= done_d;
    end
  end

  assign o_addr      = addr_o_q;
  assign o_row       = row_o_q;
  assign o_addr_vld  = vld_q;
  assign o_mac_clr   = clr_q;
  assign o_act_go    = act_q;
  assign o_step_done = sd_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_lstm_step_sched.sv
// Directed table-driven bench for lstm_step_sched (3 cols, 2 rows, 2 steps).
module tb_lstm_step_sched;

  logic clk = 1'b0;
  logic rst, i_start, i_en, i_abort;

  logic [11:0] a_addr, a_row, b_addr, b_row;
  logic a_vld, a_clr, a_act, a_sd, a_busy, a_done;
  logic b_vld, b_clr, b_act, b_sd, b_busy, b_done;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  lstm_step_sched #(.ADDR_WIDTH(12), .N_COLS(3), .N_ROWS(2), .PAUSE_LEN(2), .N_STEPS(2)) dut_a (
    .clk(clk), .rst(rst), .i_start(i_start), .i_en(i_en), .i_abort(i_abort),
    .o_addr(a_addr), .o_addr_vld(a_vld), .o_mac_clr(a_clr), .o_act_go(a_act),
    .o_row(a_row), .o_step_done(a_sd), .o_busy(a_busy), .o_done(a_done));

  lstm_step_sched #(.ADDR_WIDTH(12), .N_COLS(3), .N_ROWS(2), .PAUSE_LEN(0), .N_STEPS(2)) dut_b (
    .clk(clk), .rst(rst), .i_start(i_start), .i_en(i_en), .i_abort(i_abort),
    .o_addr(b_addr), .o_addr_vld(b_vld), .o_mac_clr(b_clr), .o_act_go(b_act),
    .o_row(b_row), .o_step_done(b_sd), .o_busy(b_busy), .o_done(b_done));

  // flags order: {vld, mac_clr, act_go, step_done, busy, done}
  typedef struct {
    logic        start, en, abort;
    logic [11:0] addr, row;
    logic [5:0]  fl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic s, input logic e, input logic a,
                             input int ad, input int rw, input logic [5:0] f);
    vec_t r;
    r.start = s; r.en = e; r.abort = a;
    r.addr = 12'(ad); r.row = 12'(rw); r.fl = f;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  logic [11:0] b_addr_exp [16];
  logic [11:0] b_row_exp  [16];
  logic [5:0]  b_fl_exp   [16];

  initial begin
    // Main run: row n = inputs applied before edge n, outputs seen after it.
    tbl.push_back(v(1,1,0, 0,0, 6'b000000));  // start accepted
    tbl.push_back(v(0,1,0, 0,0, 6'b110010));
    tbl.push_back(v(0,1,0, 1,0, 6'b100010));
    tbl.push_back(v(0,1,0, 2,0, 6'b100010));
    tbl.push_back(v(0,1,0, 3,0, 6'b000010));
    tbl.push_back(v(1,1,0, 3,0, 6'b001010));  // start ignored while busy
    tbl.push_back(v(0,1,0, 3,1, 6'b110010));
    tbl.push_back(v(0,1,0, 4,1, 6'b100010));
    tbl.push_back(v(0,1,0, 5,1, 6'b100010));
    tbl.push_back(v(0,1,0, 6,1, 6'b000010));
    tbl.push_back(v(0,1,0, 6,1, 6'b001010));
    tbl.push_back(v(0,1,0, 6,1, 6'b000110));  // step 0 done
    tbl.push_back(v(0,1,0, 0,0, 6'b110010));
    tbl.push_back(v(0,1,0, 1,0, 6'b100010));
    tbl.push_back(v(0,1,0, 2,0, 6'b100010));
    tbl.push_back(v(0,1,0, 3,0, 6'b000010));
    tbl.push_back(v(0,1,0, 3,0, 6'b001010));
    tbl.push_back(v(0,1,0, 3,1, 6'b110010));
    tbl.push_back(v(0,1,0, 4,1, 6'b100010));
    tbl.push_back(v(0,1,0, 5,1, 6'b100010));
    tbl.push_back(v(0,1,0, 6,1, 6'b000010));
    tbl.push_back(v(0,1,0, 6,1, 6'b001010));
    tbl.push_back(v(0,1,0, 6,1, 6'b000110));  // step 1 done
    tbl.push_back(v(0,1,0, 0,0, 6'b000011));  // done, 23 edges after start
    tbl.push_back(v(0,1,0, 0,0, 6'b000000));
    // Enable held low for 5 cycles at addr 1.
    tbl.push_back(v(1,1,0, 0,0, 6'b000000));
    tbl.push_back(v(0,1,0, 0,0, 6'b110010));
    tbl.push_back(v(0,0,0, 1,0, 6'b000010));
    tbl.push_back(v(0,0,0, 1,0, 6'b000010));
    tbl.push_back(v(0,0,0, 1,0, 6'b000010));
    tbl.push_back(v(0,0,0, 1,0, 6'b000010));
    tbl.push_back(v(0,0,0, 1,0, 6'b000010));
    tbl.push_back(v(0,1,0, 1,0, 6'b100010));
    tbl.push_back(v(0,1,0, 2,0, 6'b100010));
    tbl.push_back(v(0,1,0, 3,0, 6'b000010));  // in PAUSE of row 0
    tbl.push_back(v(0,1,1, 0,0, 6'b000000));  // abort
    tbl.push_back(v(0,1,0, 0,0, 6'b000000));
    tbl.push_back(v(1,1,1, 0,0, 6'b000000));  // start+abort in IDLE
    tbl.push_back(v(0,1,0, 0,0, 6'b000000));
    tbl.push_back(v(1,1,0, 0,0, 6'b000000));  // fresh start
    tbl.push_back(v(0,1,0, 0,0, 6'b110010));
    tbl.push_back(v(0,0,1, 0,0, 6'b000000));  // abort with enable low
    tbl.push_back(v(0,1,0, 0,0, 6'b000000));

    b_addr_exp = '{0,1,2,3,4,5,6,0,1,2,3,4,5,6,0,0};
    b_row_exp  = '{0,0,0,1,1,1,1,0,0,0,1,1,1,1,0,0};
    b_fl_exp   = '{6'b110010, 6'b100010, 6'b101010, 6'b110010, 6'b100010, 6'b101010,
                   6'b000110, 6'b110010, 6'b100010, 6'b101010, 6'b110010, 6'b100010,
                   6'b101010, 6'b000110, 6'b000011, 6'b000000};

    rst = 1'b1; i_start = 1'b0; i_en = 1'b1; i_abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a", {a_addr, a_row, a_vld, a_clr, a_act, a_sd, a_busy, a_done}, '0);
    chk("reset_b", {b_addr, b_row, b_vld, b_clr, b_act, b_sd, b_busy, b_done}, '0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      i_start = tbl[i].start; i_en = tbl[i].en; i_abort = tbl[i].abort;
      @(negedge clk);
      chk($sformatf("tbl%0d_addr", i), a_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_row", i), a_row, tbl[i].row);
      chk($sformatf("tbl%0d_flags", i), {a_vld, a_clr, a_act, a_sd, a_busy, a_done}, tbl[i].fl);
    end
    i_start = 1'b0; i_en = 1'b1; i_abort = 1'b0;

    // Reset while in STEP_END: step_done must never appear.
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_act", {a_act, a_addr}, {1'b1, 12'd6});
    rst = 1'b1; i_abort = 1'b1; i_en = 1'b0;
    @(negedge clk);
    chk("rst_step_end", {a_addr, a_row, a_vld, a_clr, a_act, a_sd, a_busy, a_done}, '0);
    rst = 1'b0; i_abort = 1'b0; i_en = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {a_sd, a_busy, a_done}, 3'b000);

    // Zero-length pause: back-to-back rows, act_go on last column.
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      chk($sformatf("p0_%0d_addr", n + 1), b_addr, b_addr_exp[n]);
      chk($sformatf("p0_%0d_row", n + 1), b_row, b_row_exp[n]);
      chk($sformatf("p0_%0d_flags", n + 1), {b_vld, b_clr, b_act, b_sd, b_busy, b_done}, b_fl_exp[n]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
